hps_fpga_audio_fifo: RTL and testbench

Single-clock sample FIFO between the audio codec deserializer and the HPS-readable PIO bank. It buffers signed ADC samples, hands them out one per read request, and produces the `empty`, `full`, `almost_full` and `overflow` status bits. The `empty` output drives the 1-bit FIFO-empty PIO `in_port` directly. The HPS polls that bit before draining samples.

---
 rtl/hps_fpga_audio_fifo.sv | 137 +++++++++++++
 tb/tb_hps_fpga_audio_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hps_fpga_audio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hps_fpga_audio_fifo
// Purpose  : Single-clock sample FIFO between the audio codec deserializer and
//            the HPS-readable PIO bank. Buffers signed ADC samples, returns one
//            sample per read request with a registered output, and produces the
//            empty / full / almost_full / overflow status bits.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            wr_en, wr_data    - write request and sample from deserializer
//            rd_en             - read strobe (single-cycle pulse from HPS PIO)
//            rd_data, rd_valid - registered sample and its one-cycle strobe
//            empty, full       - status (empty drives the FIFO-empty PIO)
//            almost_full       - usedw >= AFULL_LEVEL
//            usedw             - stored sample count, 0..2^ADDR_W
//            overflow, clr_ovf - sticky dropped-write flag and its clear
//            drop_count        - dropped-write counter (see macro below)
// Macro    : HPS_FPGA_AUDIO_FIFO_DROPCNT_EN - when defined, drop_count is a
//            saturating 16-bit counter; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hps_fpga_audio_fifo #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int AFULL_LEVEL = 480
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [15:0]       drop_count
);

  localparam int            DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_next;
  logic [ADDR_W:0] rd_ptr_next;
  logic [ADDR_W:0] cnt_next;
  logic            wr_ok;
  logic            rd_ok;
  logic            wr_drop;

  // Both requests are judged against the registered flags, so a full FIFO
  // still serves a read while dropping a concurrent write, and an empty FIFO
  // accepts a write while ignoring a concurrent read.
  always_comb begin
    wr_ok       = wr_en && !full;
    rd_ok       = rd_en && !empty;
    wr_drop     = wr_en && full;
    wr_ptr_next = wr_ptr + (ADDR_W+1)'(wr_ok);
    rd_ptr_next = rd_ptr + (ADDR_W+1)'(rd_ok);
    // Pointer MSB disambiguates full from empty; modular subtraction gives
    // the count directly.
    cnt_next    = wr_ptr_next - rd_ptr_next;
  end

  // Storage is not reset: after reset the pointers make old words unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      usedw       <= cnt_next;
      empty       <= (cnt_next == '0);
      full        <= (cnt_next == FULL_CNT);
      almost_full <= (cnt_next >= AFULL_CNT);
      rd_valid    <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef HPS_FPGA_AUDIO_FIFO_DROPCNT_EN
  logic [15:0] drop_cnt_r;

  // Clear and increment together restart the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r <= '0;
    end else if (wr_drop) begin
      if (clr_ovf) begin
        drop_cnt_r <= 16'd1;
      end else if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end else if (clr_ovf) begin
      drop_cnt_r <= '0;
    end
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hps_fpga_audio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_fpga_audio_fifo
// Purpose  : Self-checking bench for hps_fpga_audio_fifo (depth 8, almost-full
//            at 6). A queue-based reference model predicts every output after
//            each clock; directed sequences cover the boundary cases and a
//            randomized phase exercises mixed traffic.
// Ports    : none (top-level bench)
// Macro    : HPS_FPGA_AUDIO_FIFO_DROPCNT_EN - enables drop counter expectations
//            and the saturation sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_fpga_audio_fifo;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int AFULL  = 6;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   usedw;
  logic              overflow;
  logic              clr_ovf;
  logic [15:0]       drop_count;

  hps_fpga_audio_fifo #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .usedw      (usedw),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  int q[$];
  int m_rd;
  bit m_ovf;
  int m_dc;

  int n_chk;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef HPS_FPGA_AUDIO_FIFO_DROPCNT_EN
    return m_dc;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs(input bit exp_valid);
    check_val("rd_valid",    32'(rd_valid),    32'(exp_valid));
    check_val("rd_data",     32'(rd_data),     32'(m_rd));
    check_val("usedw",       32'(usedw),       32'(q.size()));
    check_val("empty",       32'(empty),       32'(q.size() == 0));
    check_val("full",        32'(full),        32'(q.size() == DEPTH));
    check_val("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    check_val("overflow",    32'(overflow),    32'(m_ovf));
    check_val("drop_count",  32'(drop_count),  32'(exp_drop()));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = 0;
    m_ovf = 0;
    m_dc  = 0;
  endtask

  // One clock: drive at the falling edge, update the model with the
  // pre-edge occupancy at the rising edge, compare 1 time unit later.
  task automatic step(input bit w, input int d, input bit r, input bit c, input bit chk);
    bit was_full;
    bit was_empty;
    bit got_rd;
    @(negedge clk);
    wr_en   = w;
    wr_data = d[DATA_W-1:0];
    rd_en   = r;
    clr_ovf = c;
    @(posedge clk);
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    got_rd    = 1'b0;
    if (r && !was_empty) begin
      m_rd   = q.pop_front();
      got_rd = 1'b1;
    end
    if (w && !was_full) q.push_back(d & 32'hFFFF);
    if (w && was_full) begin
      m_ovf = 1;
      if (c)               m_dc = 1;
      else if (m_dc < 65535) m_dc = m_dc + 1;
    end else if (c) begin
      m_ovf = 0;
      m_dc  = 0;
    end
    #1;
    if (chk) check_outputs(got_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill 0x0001..0x0008
    for (int i = 1; i <= DEPTH; i++) step(1, i, 0, 0, 1);
    check_val("full_after_fill", 32'(full), 32'd1);

    // Write while full, simultaneous read
    step(1, 'hAA, 1, 0, 1);
    check_val("first_out", 32'(rd_data), 32'h0001);

    // Drain remaining 7 (model confirms 0x00AA never appears)
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1);
    check_val("last_out", 32'(rd_data), 32'h0008);

    // Underflow reads
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);

    // Write + read while empty, then read it back
    step(1, 'h1234, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    check_val("rt_1234", 32'(rd_data), 32'h1234);

    // Clear overflow
    step(0, 0, 0, 1, 1);

    // 20 samples streamed through, pointers wrap twice
    for (int i = 0; i < 20; i++) step(1, 'h100 + i, i >= 3, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    check_val("stream_empty", 32'(empty), 32'd1);

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        bit w;
        bit r;
        bit c;
        w = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3));
        r = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8));
        c = ($urandom_range(0, 15) == 0);
        step(w, int'($urandom_range(0, 65535)), r, c, 1);
      end
    end

`ifdef HPS_FPGA_AUDIO_FIFO_DROPCNT_EN
    // Saturation of the drop counter
    step(0, 0, 0, 1, 1);
    while (q.size() < DEPTH) step(1, int'($urandom_range(0, 65535)), 0, 0, 1);
    step(1, 'h55, 0, 1, 1);   // clear + drop in one cycle -> 1
    check_val("dc_clr_inc", 32'(drop_count), 32'd1);
    for (int i = 0; i < 70000; i++) step(1, i, 0, 0, 0);
    #1;
    check_outputs(1'b0);
    check_val("dc_sat", 32'(drop_count), 32'hFFFF);
    step(0, 0, 0, 1, 1);
    check_val("dc_cleared", 32'(drop_count), 32'd0);
    check_val("ovf_cleared", 32'(overflow), 32'd0);
`endif

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 'h700 + i, i > 1, 0, 1);
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b1;
    step(0, 0, 1, 0, 1);
    step(1, 'hBEEF, 0, 0, 1);
    step(0, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
